// File: rtl/store_merge_unit.sv
// Store unit for the multicycle datapath: checks alignment, writes full-width stores
// directly and does read-merge-write for partial-width stores.
module store_merge_unit #(
  parameter int XLEN    = 64,
  parameter int MEM_LAT = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] store_data,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_rd_en,
  input  logic [XLEN-1:0] mem_rd_data,
  output logic            mem_wr_en,
  output logic [XLEN-1:0] mem_wr_data,
  output logic            done,
  output logic            misaligned,
  output logic            illegal
);
  localparam int NB = XLEN / 8;
  localparam int OB = $clog2(NB);
  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_WRITE, S_FAULT} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ill_q, ill_d;
  logic [2:0]      f3_q, f3_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] sd_q, sd_d;
  logic [XLEN-1:0] rd_q, rd_d;

  logic req_ill, req_mis, req_full;

  // Store bytes are pre-shifted into their lanes, then only lanes
  // [off, off+size-1] are taken from the shifted value.
  function automatic logic [XLEN-1:0] merge_bytes(input logic [XLEN-1:0] word,
                                                  input logic [XLEN-1:0] data,
                                                  input logic [OB-1:0]   off,
                                                  input logic [2:0]      f3);
    logic [XLEN-1:0] shifted;
    int              nbytes;
    shifted     = data << {off, 3'b000};
    nbytes      = 1 << f3;
    merge_bytes = word;
    for (int i = 0; i < NB; i++) begin
      if (i >= int'(off) && i < int'(off) + nbytes)
        merge_bytes[i*8 +: 8] = shifted[i*8 +: 8];
    end
  endfunction

  always_comb begin
    req_ill  = funct3[2] || (funct3 == 3'd3 && XLEN == 32);
    req_full = (funct3 == 3'(OB));
    case (funct3)
      3'd1:    req_mis = addr[0];
      3'd2:    req_mis = (addr[1:0] != 2'b00);
      3'd3:    req_mis = (addr[2:0] != 3'b000);
      default: req_mis = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ill_d   = ill_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    sd_d    = sd_q;
    rd_d    = rd_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          f3_d   = funct3;
          addr_d = addr;
          sd_d   = store_data;
          ill_d  = req_ill;
          if (req_ill || req_mis) state_d = S_FAULT;
          else if (req_full)      state_d = S_WRITE;
          else                    state_d = S_READ;
        end
      end
      S_READ: begin
        cnt_d   = CW'(MEM_LAT - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          rd_d    = mem_rd_data;
          state_d = S_WRITE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_WRITE: state_d = S_IDLE;
      S_FAULT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready   = (state_q == S_IDLE) && !reset;
    mem_rd_en   = (state_q == S_READ);
    mem_wr_en   = (state_q == S_WRITE);
    done        = (state_q == S_WRITE);
    misaligned  = (state_q == S_FAULT) && !ill_q;
    illegal     = (state_q == S_FAULT) && ill_q;
    mem_addr    = (state_q != S_IDLE) ? (addr_q & ~XLEN'(NB - 1)) : '0;
    // A full-width store replaces every lane, so the stale read word never leaks through.
    mem_wr_data = (state_q == S_WRITE) ? merge_bytes(rd_q, sd_q, addr_q[OB-1:0], f3_q) : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ill_q   <= ill_d;
    end
  end

  always_ff @(posedge clk) begin
    f3_q   <= f3_d;
    addr_q <= addr_d;
    sd_q   <= sd_d;
    rd_q   <= rd_d;
  end
endmodule
